// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer write scheduler:
//   - default active resolution (320x240)
//   - RGB444 channel/pixel widths and the packed pixel struct
//   - coordinate width of the frame-buffer write port
//   - scheduler state enumeration
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  localparam int RGB_W   = 4;
  localparam int PIX_W   = 3 * RGB_W;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_VSYNC = 2'd1,
    ST_CAPTURE    = 2'd2,
    ST_CLEAR      = 2'd3
  } fb_state_t;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb444_t;

endpackage

// File: rtl/fb_raster_counter.sv
// -----------------------------------------------------------------------------
// fb_raster_counter
// x/y raster position shared by camera capture and frame clear.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   zero           : return to (0,0); highest priority
//   raster_step    : clear walk, x wraps at H_RES-1 into the next row
//   line_step      : end of camera line, x=0 and y saturates at V_RES
//   px_step        : accepted camera pixel, x saturates at H_RES
//   x, y           : current position
//   x_in, y_in     : position lies inside the active area on that axis
//   raster_last    : position is the last pixel of the frame
// -----------------------------------------------------------------------------
module fb_raster_counter
  import fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               zero,
  input  logic               raster_step,
  input  logic               line_step,
  input  logic               px_step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               x_in,
  output logic               y_in,
  output logic               raster_last
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (zero) begin
      x <= '0;
      y <= '0;
    end else if (raster_step) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end else if (line_step) begin
      // Saturation at V_RES parks the counter outside the active area so
      // that surplus camera lines are dropped.
      x <= '0;
      if (y < Y_LIM) y <= y + 1'b1;
    end else if (px_step) begin
      if (x < X_LIM) x <= x + 1'b1;
    end
  end

  assign x_in        = (x < X_LIM);
  assign y_in        = (y < Y_LIM);
  assign raster_last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/fb_write_scheduler.sv
// -----------------------------------------------------------------------------
// fb_write_scheduler
// Arbitrates frame-buffer port-A writes between an RGB444 camera stream and a
// full-frame colour fill. A fill requested while a frame is being captured is
// deferred to the next cam_vsync so a frame is never torn.
//
// Ports
//   clk, reset_n                 : clock, asynchronous active-low reset
//   capture_en                   : 1 = capture frames, 0 = stop at frame end
//   cam_vsync, cam_href          : camera frame pulse / line level
//   pix_valid, pix_data          : camera pixel strobe and {R,G,B}
//   pix_ready                    : pixel presented now will be written
//   clear_req, clear_color       : fill request pulse and fill colour
//   write_enable                 : port-A write strobe (1 cycle after accept)
//   porta_addr_x/_y              : port-A write coordinates
//   porta_vgaRed/Green/Blue      : port-A write data
//   busy                         : scheduler not idle
//   frame_done, clear_done       : completion pulses
//   frame_count                  : completed captured frames (wraps)
//
// Build option
//   FB_FRAME_COUNTER_EN : when defined, frame_count counts completed frames;
//                         otherwise it is tied to 0 and no counter exists.
// -----------------------------------------------------------------------------
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        pix_valid,
  input  logic [11:0] pix_data,
  output logic        pix_ready,
  input  logic        clear_req,
  input  logic [11:0] clear_color,
  output logic        write_enable,
  output logic [9:0]  porta_addr_x,
  output logic [9:0]  porta_addr_y,
  output logic [3:0]  porta_vgaRed,
  output logic [3:0]  porta_vgaGreen,
  output logic [3:0]  porta_vgaBlue,
  output logic        busy,
  output logic        frame_done,
  output logic        clear_done,
  output logic [7:0]  frame_count
);

  fb_state_t          state;
  fb_state_t          state_nxt;
  logic               clr_pend;
  logic               href_d;
  rgb444_t            clr_color_q;

  logic [COORD_W-1:0] cnt_x;
  logic [COORD_W-1:0] cnt_y;
  logic               x_in;
  logic               y_in;
  logic               raster_last;

  logic               cnt_zero;
  logic               raster_step;
  logic               line_step;
  logic               pix_acc;
  logic               frame_end;
  logic               clear_start;
  logic               clear_end;

  logic               vld_p1;
  logic [COORD_W-1:0] x_p1;
  logic [COORD_W-1:0] y_p1;
  rgb444_t            rgb_p1;
  logic               frame_done_p1;
  logic               clear_done_p1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (clear_req)       state_nxt = ST_CLEAR;
        else if (capture_en) state_nxt = ST_WAIT_VSYNC;
      end
      ST_WAIT_VSYNC: begin
        if (clear_req)       state_nxt = ST_CLEAR;
        else if (!capture_en) state_nxt = ST_IDLE;
        else if (cam_vsync)  state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Frame boundary: a pending fill takes precedence over the next frame.
        if (cam_vsync) begin
          if (clr_pend || clear_req) state_nxt = ST_CLEAR;
          else if (!capture_en)      state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (raster_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy        = (state != ST_IDLE);
    pix_ready   = (state == ST_CAPTURE) && cam_href && x_in && y_in;
    pix_acc     = pix_ready && pix_valid;
    frame_end   = (state == ST_CAPTURE) && cam_vsync;
    clear_start = (state_nxt == ST_CLEAR) && (state != ST_CLEAR);
    clear_end   = (state == ST_CLEAR) && raster_last;
    raster_step = (state == ST_CLEAR);
    line_step   = (state == ST_CAPTURE) && href_d && !cam_href;
    cnt_zero    = frame_end || clear_start ||
                  ((state_nxt == ST_CAPTURE) && (state != ST_CAPTURE));
  end

  // Line-edge detector, deferred-fill flag and fill colour capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      href_d      <= 1'b0;
      clr_pend    <= 1'b0;
      clr_color_q <= '0;
    end else begin
      href_d <= cam_href;
      if (clear_start)                              clr_pend <= 1'b0;
      else if ((state == ST_CAPTURE) && clear_req)  clr_pend <= 1'b1;
      if (clear_start) clr_color_q <= rgb444_t'(clear_color);
    end
  end

  fb_raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .clk         (clk),
    .reset_n     (reset_n),
    .zero        (cnt_zero),
    .raster_step (raster_step),
    .line_step   (line_step),
    .px_step     (pix_acc),
    .x           (cnt_x),
    .y           (cnt_y),
    .x_in        (x_in),
    .y_in        (y_in),
    .raster_last (raster_last)
  );

  // Stage p1: registered port-A write and completion pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1        <= 1'b0;
      x_p1          <= '0;
      y_p1          <= '0;
      rgb_p1        <= '0;
      frame_done_p1 <= 1'b0;
      clear_done_p1 <= 1'b0;
    end else begin
      vld_p1        <= pix_acc || raster_step;
      frame_done_p1 <= frame_end;
      clear_done_p1 <= clear_end;
      if (pix_acc || raster_step) begin
        x_p1   <= cnt_x;
        y_p1   <= cnt_y;
        rgb_p1 <= raster_step ? clr_color_q : rgb444_t'(pix_data);
      end
    end
  end

  assign write_enable   = vld_p1;
  assign porta_addr_x   = x_p1;
  assign porta_addr_y   = y_p1;
  assign porta_vgaRed   = rgb_p1.r;
  assign porta_vgaGreen = rgb_p1.g;
  assign porta_vgaBlue  = rgb_p1.b;
  assign frame_done     = frame_done_p1;
  assign clear_done     = clear_done_p1;

`ifdef FB_FRAME_COUNTER_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       frame_cnt <= 8'd0;
    else if (frame_end) frame_cnt <= frame_cnt + 8'd1;
  end

  assign frame_count = frame_cnt;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
`timescale 1ns/1ps
module tb_fb_write_scheduler;

  localparam int H = 320;
  localparam int V = 240;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] pix_data = 12'h000;
  logic        clear_req = 1'b0;
  logic [11:0] clear_color = 12'h000;

  logic        pix_ready;
  logic        write_enable;
  logic [9:0]  porta_addr_x;
  logic [9:0]  porta_addr_y;
  logic [3:0]  porta_vgaRed;
  logic [3:0]  porta_vgaGreen;
  logic [3:0]  porta_vgaBlue;
  logic        busy;
  logic        frame_done;
  logic        clear_done;
  logic [7:0]  frame_count;

  fb_write_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .capture_en     (capture_en),
    .cam_vsync      (cam_vsync),
    .cam_href       (cam_href),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .clear_req      (clear_req),
    .clear_color    (clear_color),
    .write_enable   (write_enable),
    .porta_addr_x   (porta_addr_x),
    .porta_addr_y   (porta_addr_y),
    .porta_vgaRed   (porta_vgaRed),
    .porta_vgaGreen (porta_vgaGreen),
    .porta_vgaBlue  (porta_vgaBlue),
    .busy           (busy),
    .frame_done     (frame_done),
    .clear_done     (clear_done),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  // Expected write: cycle it must appear in, coordinates and {R,G,B}
  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
  } wr_t;

  wr_t         sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;

  // Reference model state: 0 idle, 1 wait vsync, 2 capture, 3 clear
  int          m_state = 0;
  logic        m_pend = 1'b0;
  int          mx = 0;
  int          my = 0;
  logic [7:0]  exp_fcnt = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] fcnt_exp();
`ifdef FB_FRAME_COUNTER_EN
    return exp_fcnt;
`else
    return 8'd0;
`endif
  endfunction

  // Write monitor / scoreboard pop
  always @(negedge clk) begin
    wr_t got;
    wr_t exp;
    if (write_enable === 1'b1) begin
      got = {32'(cyc), porta_addr_x, porta_addr_y, porta_vgaRed, porta_vgaGreen, porta_vgaBlue};
      if (sb.size() == 0) begin
        chk_eq("wr_unexpected", got, 64'h0);
      end else begin
        exp = sb.pop_front();
        chk_eq("wr", got, exp);
      end
    end
  end

  task automatic outs_zero();
    chk_eq("rst_write_enable", write_enable, 0);
    chk_eq("rst_pix_ready", pix_ready, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_frame_done", frame_done, 0);
    chk_eq("rst_clear_done", clear_done, 0);
    chk_eq("rst_frame_count", frame_count, 0);
    chk_eq("rst_addr", {porta_addr_x, porta_addr_y}, 0);
    chk_eq("rst_rgb", {porta_vgaRed, porta_vgaGreen, porta_vgaBlue}, 0);
  endtask

  // One camera line of n pixels, data = base + i*step, then one href-low cycle
  task automatic drive_line(input int n, input logic [11:0] base, input int step);
    for (int i = 0; i < n; i++) begin
      logic [11:0] d;
      logic        exp_rdy;
      d = base + 12'(i * step);
      cam_href  = 1'b1;
      pix_valid = 1'b1;
      pix_data  = d;
      @(negedge clk);
      exp_rdy = (m_state == 2) && (mx < H) && (my < V);
      chk_eq("pix_ready", pix_ready, exp_rdy);
      if (exp_rdy) begin
        sb.push_back({32'(cyc + 1), 10'(mx), 10'(my), d});
        mx++;
      end
      @(posedge clk); #1;
    end
    cam_href  = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    if (m_state == 2) begin
      mx = 0;
      if (my < V) my++;
    end
  endtask

  task automatic pulse_vsync(output int c);
    cam_vsync = 1'b1;
    @(negedge clk);
    c = cyc;
    @(posedge clk); #1;
    cam_vsync = 1'b0;
    chk_eq("frame_done", frame_done, (m_state == 2));
    if (m_state == 2) begin
      exp_fcnt = exp_fcnt + 8'd1;
      if (m_pend) begin
        m_state = 3;
        m_pend  = 1'b0;
      end else if (!capture_en) begin
        m_state = 0;
      end else begin
        mx = 0;
        my = 0;
      end
    end else if (m_state == 1) begin
      m_state = 2;
      mx = 0;
      my = 0;
    end
    chk_eq("busy_after_vsync", busy, (m_state != 0));
    chk_eq("frame_count", frame_count, fcnt_exp());
  endtask

  task automatic push_clear(input int first_cyc, input int n, input logic [11:0] col);
    for (int i = 0; i < n; i++)
      sb.push_back({32'(first_cyc + i), 10'(i % H), 10'(i / H), col});
  endtask

  task automatic wait_drain(input int bound);
    for (int k = 0; k < bound && sb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    chk_eq("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    outs_zero();
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_eq("idle_busy", busy, 0);

    // IDLE -> WAIT_VSYNC -> IDLE when capture_en drops
    capture_en = 1'b1;
    @(posedge clk); #1;
    chk_eq("wait_busy", busy, 1);
    capture_en = 1'b0;
    @(posedge clk); #1;
    chk_eq("wait_to_idle", busy, 0);

    // Two full lines of ABC, then an over-long line
    capture_en = 1'b1;
    @(posedge clk); #1;
    m_state = 1;
    pulse_vsync(c);
    drive_line(320, 12'hABC, 0);
    drive_line(320, 12'hABC, 0);
    drive_line(330, 12'h100, 7);
    wait_drain(10);

    // Fill requested mid-frame is deferred to the frame boundary
    clear_color = 12'h123;
    clear_req   = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    m_pend    = 1'b1;
    chk_eq("pend_busy", busy, 1);
    drive_line(5, 12'h5A5, 0);
    pulse_vsync(c);
    push_clear(c + 2, 1000, 12'h123);
    wait_drain(1100);

    // Reset after 1000 fill writes abandons the fill
    reset_n = 1'b0;
    #1;
    outs_zero();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_eq("no_clear_done_rst", clear_done, 0);
    end
    #1;
    reset_n  = 1'b1;
    m_state  = 0;
    m_pend   = 1'b0;
    exp_fcnt = 8'd0;
    capture_en = 1'b0;
    @(posedge clk); #1;
    chk_eq("post_rst_busy", busy, 0);
    chk_eq("post_rst_clear_done", clear_done, 0);

    // capture_en dropped mid-frame: frame completes, then IDLE
    capture_en = 1'b1;
    @(posedge clk); #1;
    m_state = 1;
    pulse_vsync(c);
    drive_line(4, 12'h3C5, 1);
    capture_en = 1'b0;
    drive_line(3, 12'h9E1, 0);
    chk_eq("cap_busy", busy, 1);
    pulse_vsync(c);
    @(posedge clk); #1;
    chk_eq("frame_done_pulse", frame_done, 0);
    chk_eq("stop_idle", busy, 0);
    chk_eq("stop_frame_count", frame_count, fcnt_exp());

    // Full-frame fill from IDLE; later request and colour change ignored
    clear_color = 12'h00F;
    clear_req   = 1'b1;
    @(negedge clk);
    c = cyc;
    @(posedge clk); #1;
    clear_req   = 1'b0;
    clear_color = 12'hFF0;
    push_clear(c + 2, H * V, 12'h00F);
    m_state = 3;
    repeat (100) @(posedge clk);
    #1;
    clear_req   = 1'b1;
    clear_color = 12'hFFF;
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_drain(H * V + 100);
    chk_eq("last_wr_en", write_enable, 1);
    chk_eq("last_addr", {porta_addr_x, porta_addr_y}, {10'd319, 10'd239});
    chk_eq("clear_done", clear_done, 1);
    chk_eq("clear_busy", busy, 0);
    @(posedge clk); #1;
    chk_eq("clear_done_pulse", clear_done, 0);
    chk_eq("idle_wr_en", write_enable, 0);
    repeat (5) @(posedge clk);
    #1;
    chk_eq("sb_final", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter H_RES, default 320, active pixels per line written to the frame buffer.
REQ-002 SHALL have parameter V_RES, default 240, active lines per frame written to the frame buffer.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port capture_en  input  1  level; 1 = capture camera frames, 0 = stop at the next frame boundary (freeze).
REQ-006 SHALL have port cam_vsync  input  1  one-cycle pulse marking frame start.
REQ-007 SHALL have port cam_href  input  1  level, high during an active camera line.
REQ-008 SHALL have port pix_valid  input  1  camera pixel strobe.
REQ-009 SHALL have port pix_data  input  12  RGB444 pixel as {R,G,B}.
REQ-010 SHALL have port pix_ready  output  1  high when a pixel presented with pix_valid is written.
REQ-011 SHALL have port clear_req  input  1  one-cycle pulse requesting a full-frame fill.
REQ-012 SHALL have port clear_color  input  12  RGB444 fill colour, sampled when clear starts.
REQ-013 SHALL have port write_enable  output  1  frame buffer port-A write strobe.
REQ-014 SHALL have ports porta_addr_x and porta_addr_y  output  10 each  write coordinates.
REQ-015 SHALL have ports porta_vgaRed, porta_vgaGreen, porta_vgaBlue  output  4 each  write data.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have ports frame_done and clear_done  output  1 each  one-cycle completion pulses.
REQ-018 SHALL have port frame_count  output  8  number of completed captured frames.

Function
REQ-019 SHALL implement the states IDLE, WAIT_VSYNC, CAPTURE and CLEAR.
REQ-020 IDLE SHALL go to CLEAR on clear_req, else to WAIT_VSYNC when capture_en=1; clear_req wins if both hold.
REQ-021 WAIT_VSYNC SHALL go to CLEAR on clear_req, to CAPTURE on cam_vsync (x=y=0), and to IDLE if capture_en=0.
REQ-022 In CAPTURE, pix_ready SHALL equal cam_href, with x<H_RES and y<V_RES; it SHALL be 0 in every other state.
REQ-023 An accepted pixel (pix_valid & pix_ready) SHALL produce write_enable=1 with its address and data registered on the next clock edge, i.e. 1-cycle latency.
REQ-024 x SHALL increment per accepted pixel and saturate at H_RES; pixels beyond it SHALL be dropped with no write.
REQ-025 On a cam_href falling edge, x SHALL return to 0 and y SHALL increment, saturating at V_RES; lines beyond it SHALL be dropped.
REQ-026 On cam_vsync in CAPTURE, the block SHALL pulse frame_done, increment frame_count (wrapping 255->0), and then either restart at x=y=0 or go to IDLE if capture_en=0.
REQ-027 A clear_req during CAPTURE SHALL be held pending and SHALL start CLEAR at the next cam_vsync, instead of restarting capture; a second request while pending SHALL merge.
REQ-028 CLEAR SHALL write clear_color to every (x,y) in raster order, one write per cycle, H_RES*V_RES writes total, with camera pixels dropped.
REQ-029 After the last clear write, the block SHALL pulse clear_done and go to IDLE; a clear_req during CLEAR SHALL be ignored.
REQ-030 write_enable SHALL never be high for a coordinate outside [0,H_RES-1]x[0,V_RES-1].

Reset
REQ-031 On reset_n low, the block SHALL enter IDLE and drive all outputs to 0, with the clear-pending flag cleared; reset mid-CLEAR or mid-CAPTURE SHALL abandon the operation without a done pulse.

Configuration
REQ-032 With macro FB_FRAME_COUNTER_EN defined, frame_count SHALL behave per REQ-026; without it, frame_count SHALL be tied to 0 and its counter SHALL be absent.

Structure
REQ-033 The state enum, the RGB444 field widths, and the defaults H_RES=320 and V_RES=240 SHALL live in the shared package fb_pkg.
REQ-034 The x/y raster counter shared by CAPTURE and CLEAR SHALL be one sub-module, fb_raster_counter.

Verification
REQ-035 Reset, capture_en=1, vsync, then 2 lines of 320 valid pixels each with pix_data=12'hABC -> 640 writes to y=0..1 of R=A, G=B, B=C, each 1 cycle after its pixel.
REQ-036 A line of 330 pixels -> writes for x=0..319 only, with pix_ready=0 for the last 10 pixels.
REQ-037 clear_req in IDLE with clear_color=12'h00F -> exactly 76800 consecutive writes, the last at (319,239), then clear_done and busy=0.
REQ-038 clear_req mid-frame -> capture continues, and at the next vsync frame_done, then CLEAR.
REQ-039 capture_en dropped mid-frame -> the frame completes, frame_done is pulsed, then IDLE with frame_count=1 (0 if FB_FRAME_COUNTER_EN is undefined).
REQ-040 reset_n asserted after 1000 clear writes -> no clear_done, all outputs 0, state IDLE.
